// File: rtl/crypt_pkg.sv
// crypt_pkg: shared state encoding, cipher constants and rotate helpers for the Crypt sequencer
package crypt_pkg;
  typedef enum logic [1:0] {IDLE, KEYGEN, ROUND, DONE} state_t;
  localparam logic [31:0] ROUND_CONST = 32'h9E3779B9;
  localparam int ROT_AMT = 3;
  localparam logic [5:0] FUNCT_ENC = 6'h30;
  localparam logic [5:0] FUNCT_DEC = 6'h31;
  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction
  function automatic logic [31:0] rotr(input logic [31:0] v, input int n);
    return (v >> n) | (v << (32 - n));
  endfunction
endpackage

// File: rtl/crypt_round.sv
// crypt_round: one ARX round plus key step; dir=0 encrypt/forward, dir=1 decrypt/inverse
module crypt_round
  import crypt_pkg::*;
(
  input  logic [31:0] x,
  input  logic [31:0] k,
  input  logic        dir,
  output logic [31:0] x_next,
  output logic [31:0] k_next,
  output logic [31:0] k_fwd
);
  assign k_fwd  = rotl(k, 1) ^ ROUND_CONST;
  assign x_next = dir ? rotr(x - k, ROT_AMT) ^ k : rotl(x ^ k, ROT_AMT) + k;
  assign k_next = dir ? rotr(k ^ ROUND_CONST, 1) : k_fwd;
endmodule

// File: rtl/crypt_sequencer.sv
// crypt_sequencer: multi-cycle Crypt controller stalling the core while the ARX cipher runs
// Optional macro CRYPT_KEY_CACHE_EN adds a one-entry last-round-key cache so repeat-key decrypts skip KEYGEN.
module crypt_sequencer
  import crypt_pkg::*;
#(
  parameter int ROUNDS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mode,
  input  logic [31:0] data_in,
  input  logic [31:0] key_in,
  output logic        stall,
  output logic        busy,
  output logic [31:0] result,
  output logic        result_valid
);
  localparam int CW = $clog2(ROUNDS + 1);
  localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);
  localparam logic [CW-1:0] KG_LAST = CW'(ROUNDS > 1 ? ROUNDS - 2 : 0);
  state_t state, state_n;
  logic [31:0] x, x_n, k, k_n, res_n, rx, rk, kf, dec_k0;
  logic [CW-1:0] cnt, cnt_n;
  logic mode_r, mode_n, rv_n, skip_kg;
  crypt_round u_round (.x(x), .k(k), .dir(mode_r), .x_next(rx), .k_next(rk), .k_fwd(kf));
`ifdef CRYPT_KEY_CACHE_EN
  logic c_valid, fill;
  logic [31:0] c_key, c_kl, key_r, fill_k;
  assign skip_kg = c_valid && c_key == key_in;
  assign dec_k0 = skip_kg ? c_kl : key_in;
  // refill when k_{R-1} is in hand: end of KEYGEN, or last encrypt round
  assign fill = (state == KEYGEN && cnt == KG_LAST) || (state == ROUND && !mode_r && cnt == LAST);
  assign fill_k = state == KEYGEN ? kf : k;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      c_valid <= 1'b0;
      c_key <= '0;
      c_kl <= '0;
      key_r <= '0;
    end else begin
      if (state == IDLE && start) key_r <= key_in;
      if (fill) begin
        c_valid <= 1'b1;
        c_key <= key_r;
        c_kl <= fill_k;
      end
    end
`else
  assign skip_kg = 1'b0;
  assign dec_k0 = key_in;
`endif
  assign stall = (state == IDLE && start) || state == KEYGEN || state == ROUND;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    x_n = x;
    k_n = k;
    mode_n = mode_r;
    cnt_n = cnt;
    res_n = result;
    rv_n = 1'b0;
    case (state)
      IDLE: if (start) begin
        x_n = data_in;
        k_n = mode ? dec_k0 : key_in;
        mode_n = mode;
        cnt_n = '0;
        state_n = (!mode || skip_kg || ROUNDS == 1) ? ROUND : KEYGEN;
      end
      KEYGEN: begin
        k_n = kf;
        cnt_n = cnt == KG_LAST ? '0 : cnt + 1'b1;
        state_n = cnt == KG_LAST ? ROUND : KEYGEN;
      end
      ROUND: begin
        x_n = rx;
        k_n = rk;
        cnt_n = cnt + 1'b1;
        if (cnt == LAST) begin
          state_n = DONE;
          res_n = rx;
          rv_n = 1'b1;
        end
      end
      DONE: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      x <= '0;
      k <= '0;
      mode_r <= 1'b0;
      cnt <= '0;
      result <= '0;
      result_valid <= 1'b0;
    end else begin
      state <= state_n;
      x <= x_n;
      k <= k_n;
      mode_r <= mode_n;
      cnt <= cnt_n;
      result <= res_n;
      result_valid <= rv_n;
    end
endmodule

// File: tb/tb_crypt_sequencer.sv
// tb_crypt_sequencer: directed checks of crypt_sequencer with ROUNDS=1 and ROUNDS=8 instances
module tb_crypt_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, start1 = 1'b0, start8 = 1'b0, mode = 1'b0;
  logic [31:0] data = '0, key = '0;
  logic stall1, busy1, rv1, stall8, busy8, rv8;
  logic [31:0] res1, res8;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  crypt_sequencer #(.ROUNDS(1)) u1 (.clk(clk), .rst_n(rst_n), .start(start1), .mode(mode), .data_in(data),
    .key_in(key), .stall(stall1), .busy(busy1), .result(res1), .result_valid(rv1));
  crypt_sequencer #(.ROUNDS(8)) u8 (.clk(clk), .rst_n(rst_n), .start(start8), .mode(mode), .data_in(data),
    .key_in(key), .stall(stall8), .busy(busy8), .result(res8), .result_valid(rv8));
  function automatic logic [31:0] enc_m(input logic [31:0] x, input logic [31:0] k, input int r);
    for (int i = 0; i < r; i++) begin
      x = x ^ k;
      x = {x[28:0], x[31:29]} + k;
      k = {k[30:0], k[31]} ^ 32'h9E3779B9;
    end
    return x;
  endfunction
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic run(input bit big, input logic m, input logic [31:0] d, input logic [31:0] k, input bit chg,
                     output logic [31:0] res, output int st, output int lat);
    @(negedge clk);
    mode = m;
    data = d;
    key = k;
    if (big) start8 = 1'b1; else start1 = 1'b1;
    st = 0;
    lat = -1;
    res = '0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (big ? stall8 : stall1) st++;
      if (big ? rv8 : rv1) begin
        lat = i;
        res = big ? res8 : res1;
        break;
      end
      if (chg && i == 1) begin
        mode = ~m;
        data = ~d;
        key = k ^ 32'h1;
      end
      @(negedge clk);
    end
    start1 = 1'b0;
    start8 = 1'b0;
  endtask
  initial begin
    logic [31:0] r, ct, r2;
    int st, lat, pulses, first, second;
    int dec_len;
`ifdef CRYPT_KEY_CACHE_EN
    dec_len = 9;
`else
    dec_len = 16;
`endif
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", {31'b0, stall8}, 32'd0);
    chk("rst_busy", {31'b0, busy8}, 32'd0);
    chk("rst_valid", {31'b0, rv8}, 32'd0);
    chk("rst_result", res8, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 1'b0, 32'h00000001, 32'h00000000, 0, r, st, lat);
    chk("r1_enc_result", r, 32'h00000008);
    chk("r1_enc_latency", lat, 2);
    chk("r1_enc_stall", st, 2);
    run(0, 1'b1, 32'h00000008, 32'h00000000, 0, r, st, lat);
    chk("r1_dec_result", r, 32'h00000001);
    chk("r1_dec_latency", lat, 2);
    chk("r1_dec_stall", st, 2);
    run(1, 1'b0, 32'h12345678, 32'hCAFEBABE, 0, ct, st, lat);
    chk("r8_enc_result", ct, enc_m(32'h12345678, 32'hCAFEBABE, 8));
    chk("r8_enc_stall", st, 9);
    chk("r8_enc_latency", lat, 9);
    run(1, 1'b1, ct, 32'hCAFEBABE, 0, r, st, lat);
    chk("r8_roundtrip", r, 32'h12345678);
    chk("r8_dec_stall", st, dec_len);
    chk("r8_dec_latency", lat, dec_len);
    @(negedge clk);
    start8 = 1'b1;
    mode = 1'b0;
    data = 32'h12345678;
    key = 32'hCAFEBABE;
    repeat (4) @(negedge clk);
    #1;
    chk("mid_busy", {31'b0, busy8}, 32'd1);
    rst_n = 1'b0;
    start8 = 1'b0;
    #1;
    chk("mid_rst_stall", {31'b0, stall8}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy8}, 32'd0);
    chk("mid_rst_valid", {31'b0, rv8}, 32'd0);
    chk("mid_rst_result", res8, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(1, 1'b1, ct, 32'hCAFEBABE, 0, r, st, lat);
    chk("post_rst_dec_result", r, 32'h12345678);
    chk("post_rst_dec_stall", st, 16);
    chk("post_rst_dec_latency", lat, 16);
    @(negedge clk);
    start8 = 1'b1;
    mode = 1'b0;
    data = 32'hA5A5A5A5;
    key = 32'h01234567;
    pulses = 0;
    first = -1;
    second = -1;
    r2 = '0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (rv8) begin
        pulses++;
        if (first < 0) first = i;
        else begin
          second = i;
          r2 = res8;
        end
      end
      if (first >= 0 && i == first + 2) start8 = 1'b0;
      @(negedge clk);
    end
    start8 = 1'b0;
    chk("b2b_pulses", pulses, 2);
    chk("b2b_first", first, 9);
    chk("b2b_second", second, 19);
    chk("b2b_result", r2, enc_m(32'hA5A5A5A5, 32'h01234567, 8));
    run(1, 1'b0, 32'h0F0F1234, 32'h89ABCDEF, 1, r, st, lat);
    chk("sampled_result", r, enc_m(32'h0F0F1234, 32'h89ABCDEF, 8));
    chk("sampled_latency", lat, 9);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/crypt_sequencer.md
# crypt_sequencer

- Multi-cycle controller for the datapath's Crypt instructions (R-type funct 0x30 encrypt, 0x31 decrypt).
- Runs a fixed-round ARX cipher over `ROUNDS` cycles and stalls the single-cycle core (PC, register file) while it works.
- Delivers the result for the `RegWriteSrc = 2'b11` writeback path.

## Interface
- `ROUNDS`, 8, number of cipher rounds; legal range 1..16.
- `clk` input 1: core clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: decoded Crypt instruction present (opcode 0x00, funct 0x30/0x31).
- `mode` input 1: 0 = encrypt (0x30), 1 = decrypt (0x31).
- `data_in` input 32: rs value.
- `key_in` input 32: rt value.
- `stall` output 1: freeze PC and suppress RegWrite.
- `busy` output 1: state ≠ IDLE.
- `result` output 32: registered cipher output.
- `result_valid` output 1: writeback strobe.

## Operation
- Cipher, with C = 32'h9E3779B9 and k0 = key_in:
  - Encrypt round r = 0..R-1: x ← rotl(x ^ k_r, 3) + k_r (mod 2^32).
  - Key step: k_{r+1} = rotl(k_r, 1) ^ C.
  - Decrypt round r = R-1..0: x ← rotr(x − k_r, 3) ^ k_r.
  - Inverse key step: k_{r−1} = rotr(k_r ^ C, 1).
- States: IDLE, KEYGEN, ROUND, DONE.
- IDLE:
  - When `start` is high, latch x = data_in, k = key_in and mode; clear the round counter.
  - Next state: encrypt → ROUND. Decrypt → KEYGEN, or straight to ROUND when ROUNDS = 1.
- KEYGEN (decrypt only):
  - Apply the forward key step once per cycle for ROUNDS−1 cycles, leaving k = k_{R−1}.
  - Then → ROUND.
- ROUND: one round per cycle for ROUNDS cycles, stepping the key after each round (forward for encrypt, inverse for decrypt). Then → DONE with `result` loaded.
- DONE:
  - `result_valid` is high for exactly one cycle, then the block returns to IDLE unconditionally.
  - `start` is ignored in DONE; it is still high from the same instruction.
- `stall` = (IDLE && start) || KEYGEN || ROUND. It is low in DONE, so the core writes back and advances the PC in that cycle.
- `mode`, `data_in` and `key_in` are sampled only at acceptance. Later changes are ignored.
- Back-to-back Crypt instructions: the second `start` is seen in IDLE the cycle after DONE and is accepted normally.
- Reset, including mid-operation:
  - Return to IDLE.
  - `stall`, `busy` and `result_valid` go to 0, and `result` goes to 0.
  - Internal registers clear, and the key cache is invalidated.

## Timing
- Acceptance cycle T (IDLE with `start` high).
- Encrypt:
  - ROUND occupies T+1..T+R; DONE is at T+R+1.
  - `stall` is high R+1 cycles; latency to `result_valid` is R+1.
- Decrypt:
  - KEYGEN occupies T+1..T+R−1, ROUND T+R..T+2R−1, DONE T+2R.
  - `stall` is high 2R cycles.
- `stall` is combinational in IDLE (from `start`) and registered-state-derived elsewhere.
- `result` and `result_valid` are registered.

## Configuration
- Macro: `CRYPT_KEY_CACHE_EN`.
- With the macro defined:
  - A single-entry cache holds {valid, key, k_{R−1}}.
  - It is filled at the end of every completed operation: at KEYGEN exit for decrypt, and in the last ROUND cycle for encrypt.
  - A decrypt whose key_in matches a valid entry loads k_{R−1} directly and skips KEYGEN. Timing then equals encrypt: DONE at T+R+1, `stall` high R+1 cycles.
  - Reset clears valid.
- Without the macro: no cache storage, and decrypt always runs KEYGEN.

## Structure
- Shared package `crypt_pkg`:
  - State encoding.
  - ROUND_CONST = 32'h9E3779B9.
  - ROT_AMT = 3.
  - Funct constants 6'h30 / 6'h31.
- Sub-module `crypt_round`: purely combinational. Computes one round plus one key step in either direction, selected by a direction input; also produces the forward key step used by KEYGEN.
- `crypt_sequencer` owns the FSM, round counter ($clog2(ROUNDS+1) bits), x/k registers, and the optional cache.

## Test plan
- ROUNDS=1, encrypt, data 0x00000001, key 0x00000000 → `result` 0x00000008; `result_valid` at T+2; `stall` high at T and T+1 only.
- ROUNDS=1, decrypt, data 0x00000008, key 0x00000000 → `result` 0x00000001; no KEYGEN cycle; DONE at T+2.
- ROUNDS=8, encrypt 0x12345678 with key 0xCAFEBABE, then decrypt the ciphertext with the same key:
  - Round-trip returns 0x12345678.
  - Encrypt `stall` lasts 9 cycles.
  - Decrypt `stall` lasts 16 cycles without the macro, or 9 cycles with `CRYPT_KEY_CACHE_EN` (cache hit).
- Back-to-back: `start` held through DONE and reasserted the next cycle → exactly two `result_valid` pulses, no extra acceptance in DONE.
- Assert `rst_n` low during ROUND (cycle T+4, ROUNDS=8):
  - Outputs go to 0 immediately, state becomes IDLE.
  - A subsequent decrypt with the same key runs the full KEYGEN (cache invalidated).
- Change `data_in`/`key_in`/`mode` after acceptance → `result` matches the values sampled at T.
